// File: rtl/alu_wide_sequencer_pkg.sv
// Shared definitions for the wide ALU sequencer.
// Holds the ALU command encoding, the bit positions inside the {n,z,c,v}
// status vector, and the sequencer state encoding.
package alu_wide_sequencer_pkg;

  // ALU command encoding (4 bits). Any other code makes the ALU output 0.
  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;

  // Bit positions inside the 4-bit status vector {n,z,c,v}.
  localparam int ST_N = 3;
  localparam int ST_Z = 2;
  localparam int ST_C = 1;
  localparam int ST_V = 0;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/alu_wide_sequencer_alu.sv
// N-bit combinational ALU.
// Ports:
//   cmd      - command (see package encoding)
//   carry_in - carry for ADC; for SBC the ALU subtracts ~carry_in
//   a, b     - operands
//   out      - result (0 for undefined commands)
//   c        - carry out for ADD/ADC, borrow (1 = borrow) for SUB/SBC,
//              0 for move and logic commands
//   v        - signed overflow for arithmetic commands, 0 otherwise
module alu_wide_sequencer_alu
  import alu_wide_sequencer_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [3:0]   cmd,
  input  logic         carry_in,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] out,
  output logic         c,
  output logic         v
);

  logic [N:0] ext;

  always_comb begin
    out = '0;
    c   = 1'b0;
    v   = 1'b0;
    ext = '0;
    case (cmd)
      CMD_MOV: out = b;
      CMD_MVN: out = ~b;
      CMD_ADD, CMD_ADC: begin
        ext = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, (cmd == CMD_ADC) & carry_in};
        out = ext[N-1:0];
        c   = ext[N];
        v   = (a[N-1] == b[N-1]) && (out[N-1] != a[N-1]);
      end
      CMD_SUB, CMD_SBC: begin
        // The top bit of the (N+1)-bit difference is the borrow.
        ext = {1'b0, a} - {1'b0, b} - {{N{1'b0}}, (cmd == CMD_SBC) & ~carry_in};
        out = ext[N-1:0];
        c   = ext[N];
        v   = (a[N-1] != b[N-1]) && (out[N-1] != a[N-1]);
      end
      CMD_AND: out = a & b;
      CMD_ORR: out = a | b;
      CMD_EOR: out = a ^ b;
      default: out = '0;
    endcase
  end

endmodule

// File: rtl/alu_wide_sequencer.sv
// Wide ALU sequencer: executes one WORDS x N-bit operation by driving a
// single N-bit ALU once per cycle, least-significant word first, chaining
// carry/borrow between words and accumulating {n,z,c,v} for the wide result.
// Ports:
//   clk, rst  - clock; synchronous active-high reset
//   start     - begin an operation (sampled only in IDLE)
//   cmd       - ALU command
//   carryIn   - external carry for ADC/SBC on word 0
//   a, b      - wide operands (latched on acceptance)
//   busy      - high in RUN and DONE
//   done      - one-cycle pulse when result/status are valid
//   result    - wide result, cleared on acceptance, held after done
//   status    - {n,z,c,v} of the wide result, written when the last word runs
// Handshake: start is honoured only when busy is low; an accepted operation
// always completes WORDS+1 cycles later with a single done pulse unless rst
// intervenes.
module alu_wide_sequencer
  import alu_wide_sequencer_pkg::*;
#(
  parameter int N     = 32,
  parameter int WORDS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [3:0]           cmd,
  input  logic                 carryIn,
  input  logic [N*WORDS-1:0]   a,
  input  logic [N*WORDS-1:0]   b,
  output logic                 busy,
  output logic                 done,
  output logic [N*WORDS-1:0]   result,
  output logic [3:0]           status
);

  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  seq_state_t         state;
  logic [N*WORDS-1:0] a_q;
  logic [N*WORDS-1:0] b_q;
  logic [3:0]         cmd_q;
  logic               cin_q;
  logic [IW-1:0]      idx;
  logic               zacc;
  logic               cprev;

  logic [N-1:0]       a_w;
  logic [N-1:0]       b_w;
  logic [3:0]         cmd_eff;
  logic               cin_eff;
  logic [N-1:0]       alu_out;
  logic               alu_c;
  logic               alu_v;
  logic               out_zero;

  assign a_w      = a_q[int'(idx)*N +: N];
  assign b_w      = b_q[int'(idx)*N +: N];
  assign out_zero = (alu_out == '0);

  // Upper words continue the arithmetic chain: ADD/ADC become ADC and
  // SUB/SBC become SBC. The ALU subtracts ~carry_in for SBC and reports
  // borrow as c=1, so the previous borrow is inverted on the way back in.
  always_comb begin
    cmd_eff = cmd_q;
    cin_eff = cin_q;
    if (idx != '0) begin
      case (cmd_q)
        CMD_ADD, CMD_ADC: cmd_eff = CMD_ADC;
        CMD_SUB, CMD_SBC: cmd_eff = CMD_SBC;
        default:          cmd_eff = cmd_q;
      endcase
      if (cmd_eff == CMD_ADC)      cin_eff = cprev;
      else if (cmd_eff == CMD_SBC) cin_eff = ~cprev;
      else                         cin_eff = 1'b0;
    end
  end

  alu_wide_sequencer_alu #(.N(N)) u_alu (
    .cmd      (cmd_eff),
    .carry_in (cin_eff),
    .a        (a_w),
    .b        (b_w),
    .out      (alu_out),
    .c        (alu_c),
    .v        (alu_v)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      status <= '0;
      idx    <= '0;
      zacc   <= 1'b0;
      cprev  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      cmd_q  <= '0;
      cin_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_q    <= a;
            b_q    <= b;
            cmd_q  <= cmd;
            cin_q  <= carryIn;
            result <= '0;
            status <= '0;
            zacc   <= 1'b1;
            cprev  <= 1'b0;
            idx    <= '0;
            busy   <= 1'b1;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          result[int'(idx)*N +: N] <= alu_out;
          zacc  <= zacc & out_zero;
          cprev <= alu_c;
          if (idx == LAST_IDX) begin
            status[ST_N] <= alu_out[N-1];
            status[ST_Z] <= zacc & out_zero;
            status[ST_C] <= alu_c;
            status[ST_V] <= alu_v;
            done         <= 1'b1;
            state        <= ST_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_wide_sequencer.sv
// Directed bench for alu_wide_sequencer with N=32, WORDS=2.
module tb_alu_wide_sequencer;

  localparam int N     = 32;
  localparam int WORDS = 2;
  localparam int W     = N * WORDS;

  localparam logic [3:0] C_MVN = 4'b1001;
  localparam logic [3:0] C_ADD = 4'b0010;
  localparam logic [3:0] C_ADC = 4'b0011;
  localparam logic [3:0] C_SUB = 4'b0100;
  localparam logic [3:0] C_EOR = 4'b1000;
  localparam logic [3:0] C_UND = 4'b1010;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   cmd;
  logic         carry_in;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [3:0]   status;

  int n_cmp = 0;
  int n_bad = 0;

  // Clock / reset
  always #5 clk = ~clk;

  alu_wide_sequencer #(.N(N), .WORDS(WORDS)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .cmd     (cmd),
    .carryIn (carry_in),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .status  (status)
  );

  // Checker
  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Driver: accept one operation, scramble inputs afterwards, and wait
  // (bounded) for done. Returns with the bench sitting on the done cycle.
  task automatic do_op(input logic [3:0] c, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic ci, output int lat, output int nbusy);
    @(negedge clk);
    cmd = c; a = av; b = bv; carry_in = ci; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = ~av; b = ~bv; cmd = C_SUB; carry_in = ~ci;
    lat = 1; nbusy = 0;
    while (!done && lat < 20) begin
      if (busy) nbusy++;
      @(negedge clk);
      lat++;
    end
    if (busy) nbusy++;
    if (!done) check_eq("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_check(input string tag, input logic [3:0] c, input logic [W-1:0] av,
                           input logic [W-1:0] bv, input logic ci,
                           input logic [W-1:0] exp_res, input logic [3:0] exp_st);
    int lat, nb;
    do_op(c, av, bv, ci, lat, nb);
    check_eq({tag, "_result"}, result, exp_res);
    check_eq({tag, "_status"}, {60'd0, status}, {60'd0, exp_st});
  endtask

  initial begin
    int lat, nb, ndone;
    rst = 1'b1; start = 1'b0; cmd = '0; carry_in = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_busy",   {63'd0, busy}, 64'd0);
    check_eq("reset_done",   {63'd0, done}, 64'd0);
    check_eq("reset_result", result, 64'd0);
    check_eq("reset_status", {60'd0, status}, 64'd0);
    rst = 1'b0;

    // 1: carry from word 0 into word 1, latency and busy length
    do_op(C_ADD, 64'h00000000_FFFFFFFF, 64'h1, 1'b0, lat, nb);
    check_eq("add_carry_result", result, 64'h00000001_00000000);
    check_eq("add_carry_status", {60'd0, status}, 64'h0);
    check_eq("add_latency", lat, 3);
    check_eq("add_busy_cycles", nb, 3);
    @(negedge clk);
    check_eq("done_one_cycle", {63'd0, done}, 64'd0);
    check_eq("busy_after_done", {63'd0, busy}, 64'd0);
    check_eq("result_held", result, 64'h00000001_00000000);

    // 2: borrow from word 0 into word 1
    run_check("sub_borrow", C_SUB, 64'h00000001_00000000, 64'h1, 1'b0, 64'h00000000_FFFFFFFF, 4'b0000);
    // 3: signed overflow, then full wrap to zero with carry out
    run_check("add_ovf",  C_ADD, 64'h7FFFFFFF_FFFFFFFF, 64'h1, 1'b0, 64'h80000000_00000000, 4'b1001);
    run_check("add_wrap", C_ADD, 64'hFFFFFFFF_FFFFFFFF, 64'h1, 1'b0, 64'h0, 4'b0110);
    // 4: logic op to zero; external carry on word 0
    run_check("eor_zero", C_EOR, 64'h12345678_9ABCDEF0, 64'h12345678_9ABCDEF0, 1'b0, 64'h0, 4'b0100);
    run_check("adc_cin",  C_ADC, 64'h0, 64'h0, 1'b1, 64'h1, 4'b0000);
    // Extra: MVN of zero, undefined command
    run_check("mvn",   C_MVN, 64'h0, 64'h0, 1'b0, 64'hFFFFFFFF_FFFFFFFF, 4'b1000);
    run_check("undef", C_UND, 64'h5, 64'h3, 1'b1, 64'h0, 4'b0100);

    // 5: start pulsed during RUN is ignored
    @(negedge clk);
    cmd = C_ADD; a = 64'h1; b = 64'h2; carry_in = 1'b0; start = 1'b1;
    @(negedge clk);
    cmd = C_SUB; a = 64'h100; b = 64'h1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    if (done) ndone++;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        check_eq("busy_start_result", result, 64'h3);
      end
    end
    check_eq("busy_start_done_count", ndone, 1);
    check_eq("busy_start_result_held", result, 64'h3);

    // 6: reset in the cycle after start abandons the operation
    @(negedge clk);
    cmd = C_ADD; a = 64'hFFFFFFFF_FFFFFFFF; b = 64'h1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_busy",   {63'd0, busy}, 64'd0);
    check_eq("abort_done",   {63'd0, done}, 64'd0);
    check_eq("abort_result", result, 64'd0);
    check_eq("abort_status", {60'd0, status}, 64'd0);
    ndone = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check_eq("abort_no_done", ndone, 0);
    run_check("after_abort", C_ADD, 64'h00000002_00000003, 64'h00000004_00000005, 1'b0,
              64'h00000006_00000008, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_wide_sequencer.md
Name: alu_wide_sequencer

Overview:
- Multi-cycle controller that executes one WORDS×N-bit ALU operation by driving a single N-bit ALU once per cycle, least-significant word first.
- Chains carry and borrow between words and accumulates the combined NZCV status.
- Sits beside the execute stage and serves wide (e.g. 64-bit) operations with the existing 32-bit ALU, so no second wide adder is needed.
- Instantiates the team's N-bit ALU internally.

Parameters:
- N, 32, width of one ALU word.
- WORDS, 2, number of words per operation; must be ≥1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin an operation; sampled only in IDLE.
- cmd  input  4  ALU command, same encoding as the ALU: MOV 0001, MVN 1001, ADD 0010, ADC 0011, SUB 0100, SBC 0101, AND 0110, ORR 0111, EOR 1000.
- carryIn  input  1  external carry for ADC/SBC on word 0.
- a  input  N*WORDS  operand A.
- b  input  N*WORDS  operand B.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; result and status valid.
- result  output  N*WORDS  wide result; held until the next accepted start or reset.
- status  output  4  {n,z,c,v} of the wide result; held like result.

Behaviour:
- **Reset** (synchronous, any state): state=IDLE, busy=0, done=0, result=0, status=0, word index=0. An operation in progress is abandoned with no done pulse.
- **IDLE:**
  - If start=1, latch a, b, cmd and carryIn. Clear the result register, set the Z accumulator to 1, set idx=0, go to RUN.
  - If start=0, stay in IDLE.
- **RUN:** one word per cycle.
  - The ALU sees a[idx], b[idx] and the effective command.
  - On the clock edge, write ALU out to result word idx.
  - Update: zacc &= (out==0); cprev = ALU c; vlast = ALU v.
  - Increment idx. When idx==WORDS-1, go to DONE.
- **DONE:** lasts exactly one cycle with done=1, then returns to IDLE.
- **Effective command:**
  - Word 0 uses the latched cmd.
  - Words >0: ADD or ADC → ADC; SUB or SBC → SBC; all other commands unchanged.
- **ALU carry input:**
  - Word 0: the latched carryIn.
  - Words >0 with ADC: cprev.
  - Words >0 with SBC: ~cprev. The ALU reports borrow as c=1 and subtracts ~carryIn, so the inversion propagates the borrow correctly.
- **Status**, written at the RUN→DONE transition:
  - n = MSB of the top word.
  - z = zacc including the last word.
  - c = ALU c of the top word (0 for logic and move commands).
  - v = ALU v of the top word.
- **Latency and throughput:**
  - start sampled at edge k; done high in the cycle following edge k+WORDS.
  - WORDS=1 gives a single RUN cycle.
  - Throughput is one operation per WORDS+2 cycles.
- **Ignored inputs:**
  - start is ignored while busy; operands are not re-latched.
  - Input changes after acceptance have no effect.
- **Undefined cmd** (0000, 1010–1111): ALU outputs 0, so result=0 and status=0100. Still completes normally with a done pulse.
- **start with rst:** start asserted in the same cycle as rst is ignored; reset wins.
- **Index width:** idx is $clog2(WORDS) bits, minimum 1. It never wraps past WORDS-1.

Decomposition:
- Shared package holds:
  - ALU command constants (MOV, MVN, ADD, ADC, SUB, SBC, AND, ORR, EOR).
  - Status bit indices (N=3, Z=2, C=1, V=0).
  - The sequencer state encoding (IDLE, RUN, DONE).
- One sub-module: the existing ALU, instantiated with N.
- The command-remapping and carry-select logic stays inline.

Test Plan:
All scenarios use N=32, WORDS=2; status is given as {n,z,c,v}.
1. ADD, a=0x00000000_FFFFFFFF, b=0x1 → result 0x00000001_00000000, status 0000; done exactly 3 cycles after start; busy high for 3 cycles.
2. SUB, a=0x00000001_00000000, b=0x1 → word-0 borrow propagates; result 0x00000000_FFFFFFFF, status 0000.
3. ADD, a=0x7FFFFFFF_FFFFFFFF, b=0x1 → result 0x80000000_00000000, status 1001. Then ADD a=all-ones, b=0x1 → result 0, status 0110.
4. EOR, a=b=0x12345678_9ABCDEF0 → result 0, status 0100. ADC with carryIn=1, a=b=0 → result 0x1, status 0000.
5. start pulsed again during RUN with different operands → ignored; first result intact; single done pulse.
6. rst asserted in the cycle after start → next cycle busy=0, done=0, result=0, status=0, and no done pulse follows. A new start then completes normally.
